sb_debug_target: RTL and testbench
==================================

SB_DEBUG_TARGET -- requirements
Module: sb_debug_target

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'h5000_0000, byte address of a 64-byte window of 16 32-bit registers; bits [5:0] zero.
REQ-002 sb_clock_i  in  1  sole clock; all logic on rising edge.
REQ-003 sb_reset_n_i  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
REQ-004 sb_begin_transaction_i  in  1  initiator starts transaction; address and control valid this cycle.
REQ-005 sb_address_data_i  in  32  address on begin, write data on write beats.
REQ-006 sb_byte_enables_i  in  4  per-byte write strobe, sampled with each write beat.
REQ-007 sb_burst_size_i  in  8  beats minus one, sampled on begin.
REQ-008 sb_read_n_write_i  in  1  1=read, 0=write, sampled on begin.
REQ-009 sb_data_valid_i  in  1  initiator write beat valid.
REQ-010 sb_end_transaction_i  in  1  initiator ends write transaction.
REQ-011 sb_busy_i  in  1  initiator stalls read beats.
REQ-012 sb_address_data_o  out  32  read data; zero when not driving a valid beat (wired-OR bus).
REQ-013 sb_data_valid_o  out  1  read beat valid.
REQ-014 sb_end_transaction_o  out  1  target ends read or error transaction, one-cycle pulse.
REQ-015 sb_error_o  out  1  one-cycle pulse, transaction rejected.
REQ-016 reg0_o  out  32  live copy of register 0 (debug LED/RGB drive).

Function
REQ-017 States: IDLE, WRITE, READ_WAIT, READ, ERROR, END.
REQ-018 IDLE: begin with address[31:6]==BASE_ADDRESS[31:6] is a hit; non-hit ignored, target stays IDLE and drives zeros.
REQ-019 Start index = address[5:2]; address[1:0] ignored.
REQ-020 Hit with start index + burst_size > 15 (9-bit arithmetic) -> ERROR next cycle: sb_error_o=1 one cycle, then END; no register modified.
REQ-021 Valid write hit -> WRITE; each cycle with sb_data_valid_i=1 writes enabled bytes to register at current index, then index increments.
REQ-022 WRITE: beats beyond burst_size+1 ignored; sb_end_transaction_i returns to IDLE same edge, including when sb_data_valid_i is high that cycle (beat still written).
REQ-023 Valid read hit -> READ_WAIT for one cycle (outputs zero), then READ; first beat is driven the second cycle after begin.
REQ-024 READ: drives register[index] with sb_data_valid_o=1 when sb_busy_i=0, then advances; when sb_busy_i=1, outputs zero, index holds.
REQ-025 After last beat (burst_size+1 beats delivered) -> END: sb_end_transaction_o=1 one cycle, then IDLE.
REQ-026 Read data reflects register contents at beat cycle.
REQ-027 sb_begin_transaction_i outside IDLE is ignored.
REQ-028 reg0_o updates the cycle after the write edge.

Reset
REQ-029 sb_reset_n_i low: state IDLE, all 16 registers zero, index and beat counter zero, all outputs zero, asynchronously.
REQ-030 Reset mid-transaction aborts it with no end pulse; first begin after reset release is processed normally.

Structure
REQ-031 Shared package sb_bus_pkg holds state encoding, register count (16), window width (6 bits), burst width (8).
REQ-032 One sub-module sb_regfile: 16x32 storage, per-byte write enable, one combinational read port, reg0 tap.

Verification
REQ-033 Single write 0xDEADBEEF, BE=4'b1111, addr BASE+0x04, then single read -> data 0xDEADBEEF valid exactly 2 cycles after read begin, end pulse next cycle.
REQ-034 Burst write 4 beats at BASE+0x20, BE=4'b0011 on beat 2 over prior 0xFFFFFFFF -> reg 9 reads 0xFFFF_xxxx with low half from beat data; 4-beat read returns 4 words in order.
REQ-035 Read burst_size=3 at BASE+0x30 with sb_busy_i high cycles 2-3 of data phase -> 4 valid beats, no duplicate or skipped word, end after 4th.
REQ-036 Begin at BASE+0x38, burst_size=2 -> sb_error_o pulse at begin+1, end pulse at begin+2, regs 14/15 unchanged.
REQ-037 Begin at BASE+0x40 -> no response, outputs stay zero.
REQ-038 Reset low during 8-beat read beat 3 -> outputs zero immediately, reg0_o=0, next read of reg 0 returns 0.

Source files
------------

// File: rtl/sb_bus_pkg.sv
// sb_bus_pkg: shared constants and state encoding for the sideband debug target.
// No ports; imported by sb_regfile and sb_debug_target.
package sb_bus_pkg;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int WIN_W    = 6;
    localparam int BURST_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ,
        ST_ERROR,
        ST_END
    } state_t;
endpackage

// File: rtl/sb_regfile.sv
// sb_regfile: 16x32 register storage with per-byte write and one combinational read port.
// Ports: clk, rst_n (async active-low clear), we/widx/wdata/be (byte-strobed write),
//        ridx/rdata (combinational read), reg0 (live tap of register 0).
module sb_regfile
    import sb_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata,
    output logic [31:0]      reg0
);
    logic [31:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        else if (we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];

    assign rdata = mem[ridx];
    assign reg0  = mem[0];
endmodule

// File: rtl/sb_debug_target.sv
// sb_debug_target: sideband bus target exposing a 64-byte window of 16 registers.
// Ports: sb_clock_i, sb_reset_n_i (async active-low); initiator side sb_begin_transaction_i,
//        sb_address_data_i, sb_byte_enables_i, sb_burst_size_i, sb_read_n_write_i,
//        sb_data_valid_i, sb_end_transaction_i, sb_busy_i; target side sb_address_data_o,
//        sb_data_valid_o, sb_end_transaction_o, sb_error_o; reg0_o live copy of register 0.
module sb_debug_target
    import sb_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000
) (
    input  logic               sb_clock_i,
    input  logic               sb_reset_n_i,
    input  logic               sb_begin_transaction_i,
    input  logic [31:0]        sb_address_data_i,
    input  logic [3:0]         sb_byte_enables_i,
    input  logic [BURST_W-1:0] sb_burst_size_i,
    input  logic               sb_read_n_write_i,
    input  logic               sb_data_valid_i,
    input  logic               sb_end_transaction_i,
    input  logic               sb_busy_i,
    output logic [31:0]        sb_address_data_o,
    output logic               sb_data_valid_o,
    output logic               sb_end_transaction_o,
    output logic               sb_error_o,
    output logic [31:0]        reg0_o
);
    state_t state, next;
    logic [IDX_W-1:0] idx;
    logic [BURST_W-1:0] burst;
    logic [BURST_W:0] cnt;
    logic [31:0] rdata;

    wire hit = sb_begin_transaction_i && sb_address_data_i[31:WIN_W] == BASE_ADDRESS[31:WIN_W];
    // Widened to 9 bits so a large burst cannot wrap back into range.
    wire [BURST_W:0] last_idx = {5'd0, sb_address_data_i[WIN_W-1:2]} + {1'b0, sb_burst_size_i};
    wire overflow = last_idx > 9'd15;
    // Beats past burst_size+1 are dropped; the range check keeps idx inside the window.
    wire write_en = state == ST_WRITE && sb_data_valid_i && cnt <= {1'b0, burst};
    wire beat = state == ST_READ && !sb_busy_i;
    wire last_beat = beat && cnt == {1'b0, burst};

    sb_regfile u_regfile (
        .clk   (sb_clock_i),
        .rst_n (sb_reset_n_i),
        .we    (write_en),
        .widx  (idx),
        .wdata (sb_address_data_i),
        .be    (sb_byte_enables_i),
        .ridx  (idx),
        .rdata (rdata),
        .reg0  (reg0_o)
    );

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i)
        if (!sb_reset_n_i) state <= ST_IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:      if (hit) next = overflow ? ST_ERROR : sb_read_n_write_i ? ST_READ_WAIT : ST_WRITE;
            ST_WRITE:     if (sb_end_transaction_i) next = ST_IDLE;
            ST_READ_WAIT: next = ST_READ;
            ST_READ:      if (last_beat) next = ST_END;
            ST_ERROR:     next = ST_END;
            ST_END:       next = ST_IDLE;
            default:      next = ST_IDLE;
        endcase
    end

    // Transaction parameters are reloaded every idle cycle; only the begin cycle's values matter.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i)
        if (!sb_reset_n_i) begin
            idx   <= '0;
            burst <= '0;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            idx   <= sb_address_data_i[WIN_W-1:2];
            burst <= sb_burst_size_i;
            cnt   <= '0;
        end else if (write_en || beat) begin
            idx <= idx + 4'd1;
            cnt <= cnt + 9'd1;
        end

    always_comb begin
        sb_data_valid_o      = beat;
        sb_address_data_o    = beat ? rdata : '0;
        sb_end_transaction_o = state == ST_END;
        sb_error_o           = state == ST_ERROR;
    end
endmodule

// File: tb/tb_sb_debug_target.sv
// tb_sb_debug_target: directed self-checking bench for sb_debug_target.
module tb_sb_debug_target;
    localparam logic [31:0] BASE = 32'h5000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic begin_t, rnw, dv, et, busy;
    logic [31:0] ad;
    logic [3:0] be;
    logic [7:0] bs;
    logic [31:0] ad_o, reg0;
    logic dv_o, end_o, err_o;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] wdat [16];
    logic [3:0] wbe [16];
    logic [31:0] rexp [16];

    always #5 clk = ~clk;

    sb_debug_target #(.BASE_ADDRESS(BASE)) dut (
        .sb_clock_i             (clk),
        .sb_reset_n_i           (rst_n),
        .sb_begin_transaction_i (begin_t),
        .sb_address_data_i      (ad),
        .sb_byte_enables_i      (be),
        .sb_burst_size_i        (bs),
        .sb_read_n_write_i      (rnw),
        .sb_data_valid_i        (dv),
        .sb_end_transaction_i   (et),
        .sb_busy_i              (busy),
        .sb_address_data_o      (ad_o),
        .sb_data_valid_o        (dv_o),
        .sb_end_transaction_o   (end_o),
        .sb_error_o             (err_o),
        .reg0_o                 (reg0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        begin_t = 0; ad = '0; be = '0; bs = '0; rnw = 1; dv = 0; et = 0; busy = 0;
    endtask

    // Begin cycle, then n data beats from wdat/wbe; end_transaction rides on the last beat.
    task automatic do_write(input logic [31:0] addr, input int bsz, input int n);
        clr(); begin_t = 1; ad = addr; bs = 8'(bsz); rnw = 0;
        cyc();
        clr();
        for (int i = 0; i < n; i++) begin
            ad = wdat[i]; be = wbe[i]; dv = 1; et = (i == n - 1);
            cyc();
        end
        clr();
    endtask

    // busy_mask bit t stalls data-phase cycle t (0-based); expected words come from rexp.
    task automatic do_read(input string tag, input logic [31:0] addr, input int n, input logic [31:0] busy_mask);
        int k = 0;
        int t = 0;
        clr(); begin_t = 1; ad = addr; bs = 8'(n - 1); rnw = 1;
        cyc();
        clr(); #2;
        check({tag, "_wait_valid"}, {31'b0, dv_o}, 0);
        check({tag, "_wait_data"}, ad_o, 0);
        cyc();
        while (k < n && t < 32) begin
            busy = busy_mask[t];
            #2;
            if (busy) begin
                check({tag, "_stall_valid"}, {31'b0, dv_o}, 0);
                check({tag, "_stall_data"}, ad_o, 0);
            end else begin
                check({tag, "_valid"}, {31'b0, dv_o}, 1);
                check({tag, $sformatf("_beat%0d", k)}, ad_o, rexp[k]);
                k++;
            end
            t++;
            cyc();
        end
        busy = 0;
        if (k < n) check({tag, "_timeout"}, 32'(k), 32'(n));
        #2;
        check({tag, "_end"}, {31'b0, end_o}, 1);
        check({tag, "_end_valid"}, {31'b0, dv_o}, 0);
        cyc();
        #2;
        check({tag, "_end_drop"}, {31'b0, end_o}, 0);
    endtask

    initial begin
        clr();
        repeat (2) cyc();
        check("rst_data", ad_o, 0);
        check("rst_ctl", {28'b0, dv_o, end_o, err_o, 1'b0}, 0);
        check("rst_reg0", reg0, 0);
        @(negedge clk);
        rst_n = 1;
        cyc();

        // single write then single read; address bits [1:0] ignored on the read
        wdat[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
        do_write(BASE + 32'h04, 0, 1);
        rexp[0] = 32'hDEAD_BEEF;
        do_read("single", BASE + 32'h07, 1, 0);

        // reg0 tap and byte strobes
        wdat[0] = 32'h00A5_5A0F; wbe[0] = 4'hF;
        do_write(BASE, 0, 1);
        check("reg0_full", reg0, 32'h00A5_5A0F);
        wdat[0] = 32'h1234_5678; wbe[0] = 4'b0100;
        do_write(BASE, 0, 1);
        check("reg0_byte2", reg0, 32'h0034_5A0F);

        // beat beyond burst_size+1 must not reach reg 3
        wdat[0] = 32'h22; wbe[0] = 4'hF;
        wdat[1] = 32'h33; wbe[1] = 4'hF;
        do_write(BASE + 32'h08, 0, 2);
        rexp[0] = 32'h22; rexp[1] = 32'h0;
        do_read("extra_beat", BASE + 32'h08, 2, 0);

        // burst write with partial strobe on beat 2 over all-ones
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hFFFF_FFFF; wbe[i] = 4'hF; end
        do_write(BASE + 32'h20, 3, 4);
        wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222; wdat[2] = 32'h3333_3333; wdat[3] = 32'h4444_4444;
        wbe[1] = 4'b0011;
        do_write(BASE + 32'h20, 3, 4);
        rexp[0] = 32'h1111_1111; rexp[1] = 32'hFFFF_2222; rexp[2] = 32'h3333_3333; rexp[3] = 32'h4444_4444;
        do_read("burst", BASE + 32'h20, 4, 0);

        // top-of-window burst read with busy stalls in data cycles 2-3
        wdat[0] = 32'hA000_0001; wdat[1] = 32'hA000_0002; wdat[2] = 32'hA000_0003; wdat[3] = 32'hA000_0004;
        for (int i = 0; i < 4; i++) wbe[i] = 4'hF;
        do_write(BASE + 32'h30, 3, 4);
        rexp[0] = 32'hA000_0001; rexp[1] = 32'hA000_0002; rexp[2] = 32'hA000_0003; rexp[3] = 32'hA000_0004;
        do_read("busy", BASE + 32'h30, 4, 32'b110);

        // out-of-window write burst: error then end, no register touched
        clr(); begin_t = 1; ad = BASE + 32'h38; bs = 8'd2; rnw = 0;
        cyc();
        clr(); dv = 1; et = 0; ad = 32'hBAD0_BAD0; be = 4'hF;
        #2;
        check("ovf_err", {30'b0, err_o, end_o}, 32'b10);
        cyc(); #2;
        check("ovf_end", {30'b0, err_o, end_o}, 32'b01);
        cyc(); clr(); #2;
        check("ovf_idle", {30'b0, err_o, end_o}, 0);
        rexp[0] = 32'hA000_0003; rexp[1] = 32'hA000_0004;
        do_read("ovf_regs", BASE + 32'h38, 2, 0);

        // 9-bit range check: index 1 + 255 must not wrap into range
        clr(); begin_t = 1; ad = BASE + 32'h04; bs = 8'hFF; rnw = 1;
        cyc();
        clr(); #2;
        check("wrap_err", {30'b0, err_o, end_o}, 32'b10);
        cyc(); #2;
        check("wrap_end", {30'b0, err_o, end_o}, 32'b01);
        cyc();

        // miss: address just past the window
        clr(); begin_t = 1; ad = BASE + 32'h40; rnw = 1;
        cyc();
        clr();
        for (int i = 0; i < 4; i++) begin
            #2;
            check("miss_data", ad_o, 0);
            check("miss_ctl", {29'b0, dv_o, end_o, err_o}, 0);
            cyc();
        end
        rexp[0] = 32'hDEAD_BEEF;
        do_read("after_miss", BASE + 32'h04, 1, 0);

        // reset during beat 3 of an 8-beat read of regs 0..7
        clr(); begin_t = 1; ad = BASE; bs = 8'd7; rnw = 1;
        cyc();
        clr(); cyc();
        rexp[0] = 32'h0034_5A0F; rexp[1] = 32'hDEAD_BEEF; rexp[2] = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("rst_rd_beat%0d", i), ad_o, rexp[i]);
            if (i < 2) cyc();
        end
        rst_n = 0;
        #1;
        check("rst_async_data", ad_o, 0);
        check("rst_async_ctl", {29'b0, dv_o, end_o, err_o}, 0);
        check("rst_async_reg0", reg0, 0);
        @(negedge clk);
        rst_n = 1;
        cyc(); #2;
        check("rst_no_end", {29'b0, dv_o, end_o, err_o}, 0);
        rexp[0] = 32'h0;
        do_read("post_rst", BASE, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
